// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the program-counter sequencer.
// Imported by the sequencer top and its next-PC mux.
package pc_sequencer_pkg;

    localparam int DEF_PC_W  = 8;
    localparam int DEF_KEY_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_LUT,
        SEL_LINK
    } sel_t;

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Next-PC priority select and mux: halt/stall > ret > call > jump > taken branch > increment.
// Purely combinational, zero latency; no flow control, the caller decides when to apply it.
module pc_sequencer_next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            halt_req,
    input  logic            stall,
    input  logic            ret,
    input  logic            call,
    input  logic            jump,
    input  logic            branch,
    input  logic            cond_flag,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] link,
    input  logic [PC_W-1:0] lut_addr,
    output sel_t            sel,
    output logic [PC_W-1:0] pc_inc,
    output logic [PC_W-1:0] next_pc,
    output logic            link_wr
);

    // Wraps modulo 2^PC_W by truncation.
    assign pc_inc = pc + 1'b1;

    always_comb begin
        sel     = SEL_INC;
        link_wr = 1'b0;
        if (halt_req || stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = SEL_LINK;
        end else if (call) begin
            sel     = SEL_LUT;
            link_wr = 1'b1;
        end else if (jump || (branch && cond_flag)) begin
            sel = SEL_LUT;
        end
    end

    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_HOLD: next_pc = pc;
            SEL_INC:  next_pc = pc_inc;
            SEL_LUT:  next_pc = lut_addr;
            SEL_LINK: next_pc = link;
            default:  next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC/fetch sequencer with run/halt control and a single-entry link register.
// Redirects land on the next edge (zero bubbles); stall holds everything for that cycle.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              KEY_W    = DEF_KEY_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch,
    input  logic             cond_flag,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] lut_key,
    input  logic [PC_W-1:0]  lut_addr,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  link,
    output logic             running,
    output logic             done
);

    state_t          state;
    sel_t            sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;
    logic            link_wr;

    assign lut_key = key;

    pc_sequencer_next_pc_mux #(
        .PC_W (PC_W)
    ) u_next_pc_mux (
        .halt_req  (halt_req),
        .stall     (stall),
        .ret       (ret),
        .call      (call),
        .jump      (jump),
        .branch    (branch),
        .cond_flag (cond_flag),
        .pc        (pc),
        .link      (link),
        .lut_addr  (lut_addr),
        .sel       (sel),
        .pc_inc    (pc_inc),
        .next_pc   (next_pc),
        .link_wr   (link_wr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            link    <= RESET_PC;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the RUN->HALTED transition raises it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    pc <= RESET_PC;
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        pc <= next_pc;
                        if (link_wr) begin
                            link <= pc_inc;
                        end
                    end
                end
                HALTED: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= RESET_PC;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pc      <= RESET_PC;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
